fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage core: holds the fetch PC, issues requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register that feeds the decoder. It applies the decoder's PC-source select to redirect fetch: predicted-taken branches and jumps from Decode, and misprediction restores from Execute. It also squashes any in-flight fetch made obsolete by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble written into IF/ID (addi x0,x0,0)

- clk  in  1  single clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk
- StallF  in  1  hazard unit: do not issue a new request
- StallD  in  1  hazard unit: hold IF/ID contents
- FlushD  in  1  hazard unit: replace IF/ID with bubble
- PCSrcE  in  2  00 = PC+4, 01 = PCTargetD (predicted taken), 10 = PCRestoreE (mispredict), 11 = treated as 00
- PCTargetD  in  32  branch/jump target computed in Decode
- PCRestoreE  in  32  PC+4 of the mispredicted branch in Execute
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word-aligned PCF)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- InstrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- One outstanding request at most. FSM states: ISSUE, WAIT, HOLD, DROP.
- ISSUE: imem_req = !StallF, imem_addr = PCF. On imem_req && imem_ready -> WAIT.
- WAIT: imem_req = 0. On imem_rvalid: if !StallD, load IF/ID {imem_rdata, PCF, PCF+4, ValidD=1}, PCF <= PCF+4, -> ISSUE. If StallD, capture word into a single-entry hold buffer -> HOLD.
- HOLD: imem_req = 0. When StallD falls, load IF/ID from the hold buffer, PCF <= PCF+4, -> ISSUE.
- DROP: imem_req = 0. Discard the next imem_rvalid, then -> ISSUE. No IF/ID update, no PC change.
- Redirect qualification: PCSrcE=10 is always honoured. PCSrcE=01 is honoured only when !StallD, because Decode asserts 01 for as long as a branch/jump sits in D. 10 has priority over 01.
- On an honoured redirect, PCF <= target (the +4 advance is suppressed). Next state:
  - In ISSUE with no accepted handshake: stay ISSUE.
  - In ISSUE with a handshake accepted this cycle: DROP.
  - In WAIT without rvalid: DROP.
  - In WAIT with rvalid: response discarded, -> ISSUE.
  - In HOLD: hold buffer invalidated, -> ISSUE.
- FlushD: IF/ID <= {NOP_INSTR, 0, 0, ValidD=0}. FlushD beats StallD and beats a same-cycle delivery; the delivered word is dropped and PCF is not advanced, so it is refetched unless redirected.
- StallD without FlushD: IF/ID holds all fields.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of targets are forced to 0.

## Timing
- Reset values: PCF = RESET_PC, state = ISSUE, imem_req = 0 while rstn is low, imem_addr = RESET_PC, InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, hold buffer empty.
- First request is on the first cycle after rstn rises.
- Zero-wait memory (ready in cycle n, rvalid in n+1): the instruction is visible on InstrD in cycle n+2. Throughput is one instruction per 2 cycles.
- Redirect in cycle n: the request for the target issues in cycle n+1 if no fetch is in flight. With a fetch in flight, it issues in the cycle after the stale rvalid.
- Reset asserted mid-operation: all state returns to reset values on that edge. Any later rvalid for the abandoned request is ignored (FSM is in ISSUE, where rvalid has no effect).

## Test plan
- Sequential fetch: RESET_PC=0, ready=1, rvalid one cycle later, words 0x00100093, 0x00200113 -> InstrD/PCD = (0x00100093, 0) then (0x00200113, 4), ValidD=1, imem_addr steps 0, 4, 8.
- Predicted taken: PCSrcE=01, PCTargetD=0x40, StallD=0 while a fetch of 0x8 is in WAIT -> 0x8 response discarded, next imem_addr=0x40, PCD=0x40.
- Mispredict with stall: PCSrcE=10, PCRestoreE=0x14 while StallD=1 and PCSrcE=01 -> PCF=0x14. The 01 is ignored.
- Decode stall: StallD=1 across an rvalid carrying 0xDEADBEEF -> IF/ID unchanged. After StallD falls, InstrD=0xDEADBEEF on the next cycle, no refetch.
- FlushD with delivery: FlushD=1 coincident with rvalid at PCF=0x10 -> InstrD=0x00000013, ValidD=0, next request to 0x10.
- Mid-fetch reset: rstn low for one cycle while in WAIT -> imem_addr=RESET_PC, ValidD=0, late rvalid ignored, request reissued.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the five-stage core. Holds the fetch PC (PCF),
// issues one request at a time to instruction memory over a valid/ready
// handshake, and loads the IF/ID pipeline register feeding the decoder.
// Redirects from Decode (predicted taken) and Execute (mispredict restore)
// retarget PCF and squash any fetch that the redirect made obsolete.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   StallF, StallD, FlushD    hazard-unit controls
//   PCSrcE                    00/11 = PC+4, 01 = PCTargetD, 10 = PCRestoreE
//   PCTargetD, PCRestoreE     redirect targets
//   imem_req, imem_addr       request valid / word-aligned address (PCF)
//   imem_ready                memory accepts the request this cycle
//   imem_rvalid, imem_rdata   response valid / instruction word
//   InstrD, PCD, PCPlus4D     IF/ID instruction, PC, PC+4
//   ValidD                    IF/ID holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetD,
    input  logic [31:0] PCRestoreE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pcf_reg, pcf_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_d_reg, pc_d_next;
    logic [31:0] pcplus4_d_reg, pcplus4_d_next;
    logic        valid_d_reg, valid_d_next;

    logic        req_int;
    logic        deliver;
    logic [31:0] deliver_word;
    logic        redir_mis;
    logic        redir_pred;
    logic        redirect;
    logic [31:0] redir_target;
    logic [31:0] pcf_plus4;

    // Decode holds 01 for as long as the branch sits in D, so a stalled D
    // must not re-apply it; the Execute restore always wins.
    assign redir_mis    = (PCSrcE == 2'b10);
    assign redir_pred   = (PCSrcE == 2'b01) && !StallD;
    assign redirect     = redir_mis || redir_pred;
    assign redir_target = redir_mis ? {PCRestoreE[31:2], 2'b00}
                                    : {PCTargetD[31:2], 2'b00};
    assign pcf_plus4    = pcf_reg + 32'd4;

    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        hold_instr_next = hold_instr_reg;
        instr_d_next    = instr_d_reg;
        pc_d_next       = pc_d_reg;
        pcplus4_d_next  = pcplus4_d_reg;
        valid_d_next    = valid_d_reg;
        req_int         = 1'b0;
        deliver         = 1'b0;
        deliver_word    = imem_rdata;

        case (state_reg)
            ST_ISSUE: begin
                req_int = !StallF;
                if (req_int && imem_ready) begin
                    // The request just accepted targets the old PC; its
                    // response must be thrown away if we redirect now.
                    state_next = redirect ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect || FlushD) begin
                        // Word is obsolete (redirect) or squashed (flush);
                        // PCF is not advanced so a flush causes a refetch.
                        state_next = ST_ISSUE;
                    end else if (StallD) begin
                        hold_instr_next = imem_rdata;
                        state_next      = ST_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end
            ST_HOLD: begin
                deliver_word = hold_instr_reg;
                if (redirect) begin
                    state_next = ST_ISSUE;
                end else if (!StallD) begin
                    deliver    = !FlushD;
                    state_next = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next = ST_ISSUE;
                end
            end
            default: begin
                state_next = ST_ISSUE;
            end
        endcase

        if (redirect) begin
            pcf_next = redir_target;
        end else if (deliver) begin
            pcf_next = pcf_plus4;
        end

        if (FlushD) begin
            instr_d_next   = NOP_INSTR;
            pc_d_next      = 32'd0;
            pcplus4_d_next = 32'd0;
            valid_d_next   = 1'b0;
        end else if (deliver) begin
            instr_d_next   = deliver_word;
            pc_d_next      = pcf_reg;
            pcplus4_d_next = pcf_plus4;
            valid_d_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= ST_ISSUE;
            pcf_reg        <= RESET_PC;
            hold_instr_reg <= 32'd0;
            instr_d_reg    <= NOP_INSTR;
            pc_d_reg       <= 32'd0;
            pcplus4_d_reg  <= 32'd0;
            valid_d_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pcf_reg        <= pcf_next;
            hold_instr_reg <= hold_instr_next;
            instr_d_reg    <= instr_d_next;
            pc_d_reg       <= pc_d_next;
            pcplus4_d_reg  <= pcplus4_d_next;
            valid_d_reg    <= valid_d_next;
        end
    end

    // No request may be presented while reset is held.
    assign imem_req  = req_int && rstn;
    assign imem_addr = pcf_reg;
    assign InstrD    = instr_d_reg;
    assign PCD       = pc_d_reg;
    assign PCPlus4D  = pcplus4_d_reg;
    assign ValidD    = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetD, PCRestoreE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetD  (PCTargetD),
        .PCRestoreE (PCRestoreE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn, sf, sd, fd, rdy, rv;
        logic [1:0]  src;
        logic [31:0] tgt, rpc, data;
        logic        exp_req;
        logic [31:0] exp_addr, exp_instr, exp_pc, exp_pc4;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rn, sf, sd, fd, rdy, rv, input logic [1:0] src,
                       input logic [31:0] tgt, rpc, data,
                       input logic er, input logic [31:0] ea, ei, ep, input logic ev);
        vec_t v;
        v.rn = rn; v.sf = sf; v.sd = sd; v.fd = fd; v.rdy = rdy; v.rv = rv;
        v.src = src; v.tgt = tgt; v.rpc = rpc; v.data = data;
        v.exp_req = er; v.exp_addr = ea; v.exp_instr = ei; v.exp_pc = ep;
        v.exp_pc4 = ev ? ep + 32'd4 : 32'd0;
        v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], 16'h0093} ^ 32'h5A00_0000;
    endfunction

    task automatic idle_inputs();
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00;
        PCTargetD = 0; PCRestoreE = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    initial begin
        int          pending;
        int          countdown;
        logic [31:0] pend_addr;
        int          delivered;
        logic        seen;
        logic [31:0] last_pcd;
        exp_t        e;

        // rn sf sd fd rdy rv src tgt rpc data | req addr instr pc valid
        add(0,0,0,0,1,0,2'b00,0,0,0,                     0,32'h0,NOP,32'h0,0);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h0,NOP,32'h0,0);
        add(1,0,0,0,1,1,2'b00,0,0,32'h00100093,          0,32'h0,NOP,32'h0,0);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h4,32'h00100093,32'h0,1);
        add(1,0,0,0,1,1,2'b00,0,0,32'h00200113,          0,32'h4,32'h00100093,32'h0,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h8,32'h00200113,32'h4,1);
        add(1,0,0,0,0,0,2'b01,32'h40,0,0,                0,32'h8,32'h00200113,32'h4,1);
        add(1,0,0,0,0,1,2'b00,0,0,32'hBAD00008,          0,32'h40,32'h00200113,32'h4,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h40,32'h00200113,32'h4,1);
        add(1,0,0,0,0,1,2'b00,0,0,32'h00000517,          0,32'h40,32'h00200113,32'h4,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h44,32'h00000517,32'h40,1);
        add(1,0,1,0,0,0,2'b01,32'h80,0,0,                1,32'h44,32'h00000517,32'h40,1);
        add(1,0,1,0,0,0,2'b10,0,32'h14,0,                1,32'h44,32'h00000517,32'h40,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h14,32'h00000517,32'h40,1);
        add(1,0,1,0,0,1,2'b00,0,0,32'hDEADBEEF,          0,32'h14,32'h00000517,32'h40,1);
        add(1,0,1,0,0,0,2'b00,0,0,0,                     0,32'h14,32'h00000517,32'h40,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     0,32'h14,32'h00000517,32'h40,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h18,32'hDEADBEEF,32'h14,1);
        add(1,0,0,0,0,1,2'b00,0,0,32'h00C00093,          0,32'h18,32'hDEADBEEF,32'h14,1);
        add(1,0,0,0,0,0,2'b10,0,32'h13,0,                1,32'h1C,32'h00C00093,32'h18,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h10,32'h00C00093,32'h18,1);
        add(1,0,0,1,0,1,2'b00,0,0,32'h12345678,          0,32'h10,32'h00C00093,32'h18,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h10,NOP,32'h0,0);
        add(0,0,0,0,0,0,2'b00,0,0,0,                     0,32'h10,NOP,32'h0,0);
        add(1,0,0,0,0,1,2'b00,0,0,32'hFFFFFFFF,          1,32'h0,NOP,32'h0,0);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h0,NOP,32'h0,0);
        add(1,0,0,0,0,1,2'b00,0,0,32'h00100093,          0,32'h0,NOP,32'h0,0);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h4,32'h00100093,32'h0,1);
        add(1,1,0,0,1,0,2'b00,0,0,0,                     0,32'h4,32'h00100093,32'h0,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h4,32'h00100093,32'h0,1);
        add(1,0,0,0,0,0,2'b10,0,32'hFFFFFFFC,0,          1,32'h4,32'h00100093,32'h0,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'hFFFFFFFC,32'h00100093,32'h0,1);
        add(1,0,0,0,0,1,2'b00,0,0,32'hCAFE0013,          0,32'hFFFFFFFC,32'h00100093,32'h0,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h0,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     1,32'h0,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,0,1,2'b01,32'h200,0,32'h77777777,    0,32'h0,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h200,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,1,0,2'b01,32'h300,0,0,               1,32'h200,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,1,0,2'b00,0,0,0,                     0,32'h300,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,0,1,2'b00,0,0,32'h00000099,          0,32'h300,32'hCAFE0013,32'hFFFFFFFC,1);
        add(1,0,0,0,0,0,2'b00,0,0,0,                     1,32'h300,32'hCAFE0013,32'hFFFFFFFC,1);

        rstn = 0;
        idle_inputs();
        repeat (2) @(posedge clk);

        // Directed table: inputs on the falling edge, outputs checked 1ns later.
        foreach (vecs[i]) begin
            @(negedge clk);
            rstn        = vecs[i].rn;
            StallF      = vecs[i].sf;
            StallD      = vecs[i].sd;
            FlushD      = vecs[i].fd;
            imem_ready  = vecs[i].rdy;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].data;
            PCSrcE      = vecs[i].src;
            PCTargetD   = vecs[i].tgt;
            PCRestoreE  = vecs[i].rpc;
            #1;
            $display("step %0d: req=%0b addr=%h InstrD=%h PCD=%h ValidD=%0b",
                     i, imem_req, imem_addr, InstrD, PCD, ValidD);
            chk("imem_req",  i, {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            chk("imem_addr", i, imem_addr, vecs[i].exp_addr);
            chk("InstrD",    i, InstrD, vecs[i].exp_instr);
            chk("PCD",       i, PCD, vecs[i].exp_pc);
            chk("PCPlus4D",  i, PCPlus4D, vecs[i].exp_pc4);
            chk("ValidD",    i, {31'd0, ValidD}, {31'd0, vecs[i].exp_valid});
        end

        // Scoreboard run: random ready, latency, StallF and StallD.
        @(negedge clk);
        idle_inputs();
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        pending = 0; countdown = 0; pend_addr = 0;
        delivered = 0; seen = 0; last_pcd = 0;
        for (int cyc = 0; cyc < 3000 && delivered < 40; cyc++) begin
            @(negedge clk);
            StallD      = ($urandom_range(0, 3) == 0);
            StallF      = ($urandom_range(0, 4) == 0);
            imem_rvalid = 0;
            imem_rdata  = 32'h0;
            if (pending != 0) begin
                if (countdown == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem_word(pend_addr);
                    pending     = 0;
                end else begin
                    countdown--;
                end
            end
            imem_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (ValidD && (!seen || PCD != last_pcd)) begin
                seen     = 1;
                last_pcd = PCD;
                delivered++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got PCD=%h, expected no delivery", PCD);
                end else begin
                    e = sb.pop_front();
                    $display("deliver %0d: InstrD=%h PCD=%h", delivered, InstrD, PCD);
                    chk("sb_instr", delivered, InstrD, e.instr);
                    chk("sb_pc",    delivered, PCD, e.pc);
                    chk("sb_pc4",   delivered, PCPlus4D, e.pc + 32'd4);
                end
            end
            if (imem_req && imem_ready) begin
                e.instr = mem_word(imem_addr);
                e.pc    = imem_addr;
                sb.push_back(e);
                pending   = 1;
                countdown = $urandom_range(0, 2);
                pend_addr = imem_addr;
            end
        end
        chk("sb_delivered", 0, delivered, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
